fetch_stage: RTL and testbench

Instruction-fetch stage of the MIPS pipeline: owns the program counter, drives the fetch address into the byte-addressed, big-endian instruction memory, and captures the returned word into the IF/ID pipeline register. Handles sequential fetch, jumps resolved in ID, taken branches resolved in EX, hazard-unit stalls and flushes. There are no delay slots: every redirect squashes the younger fetched instructions.

---
 rtl/fetch_stage.sv | 112 +++++++++++
 tb/tb_fetch_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage.
// Owns the PC, drives the instruction-memory address and registers the
// returned word into IF/ID. Handles branches from EX, jumps from ID,
// hazard-unit stalls and the bubbles that squash wrong-path fetches.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        misalign_fault,
    output logic [31:0] fetch_count
);

    // Byte-address mask of the instruction memory (IMEM_BYTES is a power of two).
    localparam logic [31:0] ADDR_MASK = 32'(IMEM_BYTES - 1);

    // Reduce any address into the memory range.
    function automatic logic [31:0] wrap_addr(input logic [31:0] a);
        return a & ADDR_MASK;
    endfunction

    // Force a redirect target onto a word boundary.
    function automatic logic [31:0] align_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [31:0] count_q, count_d;

    logic [31:0] seq_pc;
    logic [31:0] jump_target;

    assign seq_pc      = wrap_addr(pc_q + 32'd4);
    // The jump region comes from the PC+4 of the jump itself, which sits in IF/ID.
    assign jump_target = {pc_plus4_q[31:28], jump_index, 2'b00};

    // Next-state selection: reset, branch, stall, jump, sequential (first match wins).
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        count_d    = count_q;

        if (reset) begin
            pc_d       = wrap_addr(RESET_PC);
            instr_d    = 32'h0;
            pc_plus4_d = 32'h0;
            valid_d    = 1'b0;
            fault_d    = 1'b0;
            count_d    = 32'h0;
        end else if (branch_taken) begin
            // Branch overrides a concurrent stall; both younger slots are squashed.
            pc_d       = wrap_addr(align_addr(branch_target));
            instr_d    = 32'h0;
            pc_plus4_d = 32'h0;
            valid_d    = 1'b0;
            if (branch_target[1:0] != 2'b00) begin
                fault_d = 1'b1;
            end
        end else if (stall) begin
            // Hold everything; a pending jump is re-presented by ID later.
        end else if (jump) begin
            pc_d       = wrap_addr(align_addr(jump_target));
            instr_d    = 32'h0;
            pc_plus4_d = 32'h0;
            valid_d    = 1'b0;
        end else begin
            pc_d       = seq_pc;
            instr_d    = instruction;
            pc_plus4_d = seq_pc;
            valid_d    = 1'b1;
            if (count_q != 32'hFFFF_FFFF) begin
                count_d = count_q + 32'd1;
            end
        end
    end

    // PC, IF/ID register, sticky fault and fetch counter.
    always_ff @(posedge clk) begin
        pc_q       <= pc_d;
        instr_q    <= instr_d;
        pc_plus4_q <= pc_plus4_d;
        valid_q    <= valid_d;
        fault_q    <= fault_d;
        count_q    <= count_d;
    end

    assign pc_out         = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc_plus4_q;
    assign if_id_valid    = valid_q;
    assign misalign_fault = fault_q;
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage.
// Every driven cycle pushes the expected post-edge state; it is popped and
// compared one time unit after the rising edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_out;
    logic [31:0] instruction;
    logic        stall;
    logic        jump;
    logic [25:0] jump_index;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        misalign_fault;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [256];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pp4;
        logic        valid;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    // Reference state (what the stage should hold after the last edge).
    logic [31:0] m_pc, m_instr, m_pp4, m_cnt;
    logic        m_valid, m_mis;

    fetch_stage #(.RESET_PC(32'h0), .IMEM_BYTES(1024)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_out         (pc_out),
        .instruction    (instruction),
        .stall          (stall),
        .jump           (jump),
        .jump_index     (jump_index),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .misalign_fault (misalign_fault),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory, big-endian words indexed by pc_out.
    assign instruction = mem[pc_out[9:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the result, clock, and compare.
    task automatic step(input logic r, input logic br, input logic [31:0] tgt,
                        input logic st, input logic j, input logic [25:0] idx);
        exp_t e;
        exp_t got;
        reset         = r;
        branch_taken  = br;
        branch_target = tgt;
        stall         = st;
        jump          = j;
        jump_index    = idx;

        e = '{pc: m_pc, instr: m_instr, pp4: m_pp4, valid: m_valid, mis: m_mis, cnt: m_cnt};
        if (r) begin
            e = '{pc: 32'h0, instr: 32'h0, pp4: 32'h0, valid: 1'b0, mis: 1'b0, cnt: 32'h0};
        end else if (br) begin
            e.pc    = tgt & 32'h0000_03FC;
            e.instr = 32'h0;
            e.pp4   = 32'h0;
            e.valid = 1'b0;
            if (tgt[1:0] != 2'b00) e.mis = 1'b1;
        end else if (st) begin
            // hold
        end else if (j) begin
            e.pc    = {m_pp4[31:28], idx, 2'b00} & 32'h0000_03FC;
            e.instr = 32'h0;
            e.pp4   = 32'h0;
            e.valid = 1'b0;
        end else begin
            e.instr = mem[m_pc[9:2]];
            e.pp4   = (m_pc + 32'd4) & 32'h0000_03FF;
            e.pc    = (m_pc + 32'd4) & 32'h0000_03FF;
            e.valid = 1'b1;
            if (m_cnt != 32'hFFFF_FFFF) e.cnt = m_cnt + 32'd1;
        end
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check("pc_out",         pc_out,                got.pc);
        check("if_id_instr",    if_id_instr,           got.instr);
        check("if_id_pc_plus4", if_id_pc_plus4,        got.pp4);
        check("if_id_valid",    32'(if_id_valid),      32'(got.valid));
        check("misalign_fault", 32'(misalign_fault),   32'(got.mis));
        check("fetch_count",    fetch_count,           got.cnt);
        m_pc    = got.pc;
        m_instr = got.instr;
        m_pp4   = got.pp4;
        m_valid = got.valid;
        m_mis   = got.mis;
        m_cnt   = got.cnt;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 26'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | (i * 32'h0001_0101);
        m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_cnt = 32'h0;
        m_valid = 1'b0; m_mis = 1'b0;
        reset = 1'b1; branch_taken = 1'b0; branch_target = 32'h0;
        stall = 1'b0; jump = 1'b0; jump_index = 26'h0;

        // Reset state.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 26'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 26'h0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_valid", 32'(if_id_valid), 32'h0);

        // Free run: first load shows W0, then stall with pc_out = 8.
        run(1);
        check("first_instr", if_id_instr, mem[0]);
        check("first_valid", 32'(if_id_valid), 32'h1);
        run(1);
        check("pc_at_8", pc_out, 32'h8);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 26'h0);
            check("stall_pc", pc_out, 32'h8);
            check("stall_instr", if_id_instr, mem[1]);
            check("stall_pp4", if_id_pc_plus4, 32'h8);
            check("stall_cnt", fetch_count, 32'd2);
        end
        run(1);
        check("rel_instr", if_id_instr, mem[2]);
        check("rel_pp4", if_id_pc_plus4, 32'd12);
        run(1);
        check("cnt4", fetch_count, 32'd4);

        // Jump to 0x40, then jump held off by stall.
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 26'h10);
        check("jump_pc", pc_out, 32'h40);
        check("jump_bubble", 32'(if_id_valid), 32'h0);
        run(1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 26'h10);
        check("jstall_pc", pc_out, 32'h44);
        check("jstall_valid", 32'(if_id_valid), 32'h1);

        // Branch beats stall; misaligned target aligns and sets sticky fault.
        step(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 26'h0);
        check("br_pc", pc_out, 32'h100);
        check("br_bubble", 32'(if_id_valid), 32'h0);
        run(1);
        check("br_target_instr", if_id_instr, mem[64]);
        step(1'b0, 1'b1, 32'h102, 1'b0, 1'b0, 26'h0);
        check("mis_pc", pc_out, 32'h100);
        check("mis_set", 32'(misalign_fault), 32'h1);
        run(3);
        check("mis_sticky", 32'(misalign_fault), 32'h1);

        // Wrap at the top of memory.
        step(1'b0, 1'b1, 32'd1020, 1'b0, 1'b0, 26'h0);
        run(1);
        check("wrap_pc", pc_out, 32'h0);
        check("wrap_pp4", if_id_pc_plus4, 32'h0);
        check("wrap_instr", if_id_instr, mem[255]);

        // Randomised mix of stalls, jumps and branches (targets may exceed memory).
        for (int i = 0; i < 60; i++) begin
            logic b, s, jj;
            logic [31:0] t;
            b  = ($urandom_range(0, 7) == 0);
            s  = ($urandom_range(0, 3) == 0);
            jj = ($urandom_range(0, 5) == 0);
            t  = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            step(1'b0, b, t, s, jj, 26'($urandom));
        end

        // Reset mid-stream with everything else asserted.
        step(1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 26'h3);
        check("mrst_pc", pc_out, 32'h0);
        check("mrst_instr", if_id_instr, 32'h0);
        check("mrst_pp4", if_id_pc_plus4, 32'h0);
        check("mrst_mis", 32'(misalign_fault), 32'h0);
        check("mrst_cnt", fetch_count, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 26'h0);
        check("post_rst_instr", if_id_instr, mem[0]);

        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
